// File: rtl/div_unit_if.sv
// Operand/result bundle between the control FSM (master) and the sequential divider (slave).
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             start;
    logic             busy;
    logic             stop;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output a, b, start,
        input  busy, stop, div_zero, hi, lo
    );

    modport slave (
        input  a, b, start,
        output busy, stop, div_zero, hi, lo
    );
endinterface

// File: rtl/div_unit.sv
// Sequential signed restoring divider: quotient to lo, remainder to hi.
// One quotient bit per cycle on magnitudes, sign fix-up on the way out.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    div_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ZERO} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] b_mag;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // One extra bit so the trial subtract sees a borrow instead of wrapping.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, b_mag};
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rem          <= '0;
            quo          <= '0;
            b_mag        <= '0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            bus.busy     <= 1'b0;
            bus.stop     <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.hi       <= '0;
            bus.lo       <= '0;
        end else begin
            bus.stop     <= 1'b0;
            bus.div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.b == '0) begin
                            state        <= ZERO;
                            bus.div_zero <= 1'b1;
                        end else begin
                            state    <= RUN;
                            bus.busy <= 1'b1;
                            // Unsigned magnitudes: -2^(WIDTH-1) maps onto itself safely.
                            quo      <= bus.a[WIDTH-1] ? -bus.a : bus.a;
                            b_mag    <= bus.b[WIDTH-1] ? -bus.b : bus.b;
                            rem      <= '0;
                            sign_q   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                            sign_r   <= bus.a[WIDTH-1];
                            cnt      <= CNT_W'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                    end
                end
                DONE: begin
                    bus.lo   <= sign_q ? -quo : quo;
                    bus.hi   <= sign_r ? -rem : rem;
                    bus.stop <= 1'b1;
                    state    <= IDLE;
                end
                ZERO: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed results, divide-by-zero,
// ignored start while busy and asynchronous reset mid-operation.
module tb_div_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive start for exactly one edge (edge 0), then scramble the operands.
    task automatic kick(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    // k counts negedges after edge 0; stop is due in the cycle after edge 33.
    task automatic wait_result(input string tag, input logic [31:0] exp_lo,
                               input logic [31:0] exp_hi, input int inject_at);
        int k;
        int busy_cnt = 0;
        int zero_cnt = 0;
        bit seen = 0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == inject_at) begin
                bus.a     = 32'd1;
                bus.b     = 32'd1;
                bus.start = 1'b1;
            end else if (k == inject_at + 1) begin
                bus.start = 1'b0;
            end
            if (bus.busy) busy_cnt++;
            if (bus.div_zero) zero_cnt++;
            if (bus.stop) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_latency"}, 32'(k), 32'd33);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd32);
        check({tag, "_no_zero"}, 32'(zero_cnt), 32'd0);
        check({tag, "_lo"}, bus.lo, exp_lo);
        check({tag, "_hi"}, bus.hi, exp_hi);
        if (seen) begin
            @(negedge clk);
            check({tag, "_stop_pulse"}, 32'(bus.stop), 32'd0);
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        kick(a, b);
        wait_result(tag, exp_lo, exp_hi, -5);
    endtask

    initial begin
        int stray;
        bus.a = '0;
        bus.b = '0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_stop", 32'(bus.stop), 32'd0);
        check("rst_div_zero", 32'(bus.div_zero), 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_div("p7_p2", 32'd7, 32'd2, 32'd3, 32'd1);
        run_div("m7_p2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("p7_m2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_div("m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);

        // Divide by zero must leave the preloaded result untouched.
        run_div("preload", 32'd100, 32'd7, 32'd14, 32'd2);
        kick(32'd5, 32'd0);
        @(negedge clk);
        check("dz_pulse", 32'(bus.div_zero), 32'd1);
        check("dz_stop", 32'(bus.stop), 32'd0);
        check("dz_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("dz_pulse_end", 32'(bus.div_zero), 32'd0);
        stray = 0;
        repeat (36) begin
            @(negedge clk);
            if (bus.stop || bus.busy || bus.div_zero) stray++;
        end
        check("dz_quiet", 32'(stray), 32'd0);
        check("dz_hi_kept", bus.hi, 32'd2);
        check("dz_lo_kept", bus.lo, 32'd14);

        run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_div("min_by_1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0);
        run_div("small", 32'd3, 32'd10, 32'd0, 32'd3);

        // A start pulse mid-run is ignored.
        kick(32'd100, 32'd7);
        wait_result("ignore", 32'd14, 32'd2, 10);

        // Reset mid-run aborts at once and emits nothing afterwards.
        run_div("pre_rst", 32'd7, 32'd2, 32'd3, 32'd1);
        kick(32'd100, 32'd7);
        repeat (15) @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_stop", 32'(bus.stop), 32'd0);
        check("arst_div_zero", 32'(bus.div_zero), 32'd0);
        check("arst_hi", bus.hi, 32'd0);
        check("arst_lo", bus.lo, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.stop || bus.busy || bus.div_zero) stray++;
        end
        check("arst_quiet", 32'(stray), 32'd0);
        run_div("post_rst", 32'd7, 32'd2, 32'd3, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Sequential signed 32-bit integer divider for the multicycle MIPS datapath.
- Sits between the A/B operand registers and the HI/LO mux/register pair.
- Dividend comes from A and divisor from B. Quotient goes to LO and remainder goes to HI.
- The control FSM starts it with a one-cycle pulse. It waits on stop (done) or div_zero (exception) before writing HI/LO.

Parameters:
- WIDTH, 32, operand/result width. Iteration count equals WIDTH. Only 32 is required to be verified.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. reset=0 clears all state immediately.
- a  input  WIDTH  dividend, two's complement. Sampled only on an accepted start.
- b  input  WIDTH  divisor, two's complement. Sampled only on an accepted start.
- start  input  1  one-cycle request. Accepted only in IDLE.
- busy  output  1  high while an operation is in progress (RUN state).
- stop  output  1  one-cycle pulse: hi/lo now hold a valid result.
- div_zero  output  1  one-cycle pulse: divisor was zero, no result produced.
- hi  output  WIDTH  remainder.
- lo  output  WIDTH  quotient.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE.
  - busy=0, stop=0, div_zero=0, hi=0, lo=0.
  - Internal counter, remainder, quotient and sign flags cleared.
- States: IDLE, RUN, DONE, ZERO.
- IDLE:
  - start=1 with b!=0 latches the following, then goes to RUN:
    - |a| and |b| as unsigned magnitudes;
    - sign_q = a[31]^b[31];
    - sign_r = a[31];
    - counter = WIDTH.
  - start=1 with b==0 goes to ZERO. Nothing else is latched.
  - start=0: stay in IDLE.
- RUN: restoring division, one quotient bit per cycle, MSB first.
  - Shift {rem, quo} left by 1.
  - Trial-subtract |b| from rem, using a WIDTH+1-bit subtract.
  - If the result is non-negative: rem=diff and the quotient LSB is 1. Otherwise the LSB is 0.
  - counter decrements each cycle. After the WIDTH-th iteration go to DONE.
  - busy=1 throughout RUN.
- DONE (one cycle):
  - lo = sign_q ? -quo : quo.
  - hi = sign_r ? -rem : rem.
  - Both are registered on entry, so they are visible in the same cycle stop=1.
  - stop=1, then return to IDLE.
- ZERO (one cycle):
  - div_zero=1, then return to IDLE.
  - hi and lo keep their previous values.
  - stop is NOT asserted.
- Latency:
  - start accepted at edge 0, RUN spans edges 1..32, stop is high in the cycle after edge 33.
  - Total is 33 cycles from start to stop for WIDTH=32.
  - div_zero is high in the cycle after the start edge (1 cycle).
- Result semantics:
  - Quotient truncates toward zero.
  - Remainder has the sign of the dividend, or is 0.
  - a = q*b + r holds mod 2^32.
- Overflow case 0x80000000 / 0xFFFFFFFF:
  - lo=0x80000000, hi=0.
  - Produced naturally by magnitude arithmetic. No flag.
- Magnitude of 0x80000000 is 0x80000000 treated as unsigned. The internal datapath must not sign-overflow.
- hi and lo hold their last result until the next DONE or reset. They are never cleared by start.
- start while busy, or in DONE/ZERO, is ignored. No queuing and no restart.
- a and b may change freely after the start edge. The result depends only on the values sampled at acceptance.
- stop and div_zero are never high together.
- Reset asserted mid-operation aborts immediately to the reset values. No pulse is emitted after reset releases.

Test Plan:
- Reset, then a=7, b=2, start for 1 cycle -> busy high for 32 cycles; stop pulses exactly 33 cycles after start; lo=3, hi=1.
- a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- a=7, b=0xFFFFFFFE (-2) -> lo=0xFFFFFFFD, hi=1. Then a=-7, b=-2 -> lo=3, hi=0xFFFFFFFF.
- Preload hi/lo via a=100, b=7 (lo=14, hi=2), then a=5, b=0 -> div_zero high for exactly 1 cycle after start, stop never high, hi=2 and lo=14 unchanged, busy=0.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Also a=0x80000000, b=1 -> lo=0x80000000, hi=0. Also a=3, b=10 -> lo=0, hi=3.
- Start a=100, b=7, then at cycle 10 pulse start with a=1, b=1 -> ignored; result lo=14, hi=2 at cycle 33. Repeat and drive reset=0 at cycle 15 -> all outputs 0 immediately, no stop after release, and the next start works normally.
